// File: rtl/router_pkg.sv
// Shared router types and window-geometry helpers.
// WINDOW_LOADER_PAD_EN selects zero padding of (KERNEL-1)/2.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE,
    WAIT,
    CLEAR
  } loader_state_t;

`ifdef WINDOW_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  function automatic int ntap(input int k);
    return k * k;
  endfunction

  function automatic int pad_size(input int k);
    return PAD_EN ? (k - 1) / 2 : 0;
  endfunction

  function automatic int out_dim(
    input int img,
    input int k,
    input int s,
    input int p
  );
    return (img + 2 * p - k) / s + 1;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window/tap counters and SRAM tap address for window_loader.
// WINDOW_LOADER_PAD_EN enables the out-of-bounds tap flag.
module window_addr_gen
  import router_pkg::*;
#(
  parameter int KERNEL     = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = 16,
  localparam int NTAP      = ntap(KERNEL),
  localparam int TW        = $clog2(NTAP)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  load,
  input  logic                  step_tap,
  input  logic                  step_win,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  inb,
  output logic [TW-1:0]         tap,
  output logic                  last_tap,
  output logic                  last_win
);

  localparam int P  = pad_size(KERNEL);
  localparam int OW = out_dim(IMG_W, KERNEL, STRIDE, P);
  localparam int OH = out_dim(IMG_H, KERNEL, STRIDE, P);
  localparam int KW = $clog2(KERNEL + 1);
  localparam int XW = $clog2(OW + 1);
  localparam int YW = $clog2(OH + 1);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [KW-1:0]         kx, ky;
  logic [XW-1:0]         ox;
  logic [YW-1:0]         oy;
  int                    row, col;

  assign last_tap = (kx == KW'(KERNEL - 1)) &&
                    (ky == KW'(KERNEL - 1));
  assign last_win = (ox == XW'(OW - 1)) &&
                    (oy == YW'(OH - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      base_q <= '0;
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
    end else if (load) begin
      base_q <= base;
      kx     <= '0;
      ky     <= '0;
      ox     <= '0;
      oy     <= '0;
    end else begin
      if (step_tap) begin
        if (kx == KW'(KERNEL - 1)) begin
          kx <= '0;
          ky <= last_tap ? '0 : ky + KW'(1);
        end else begin
          kx <= kx + KW'(1);
        end
      end
      if (step_win) begin
        if (ox == XW'(OW - 1)) begin
          ox <= '0;
          oy <= oy + YW'(1);
        end else begin
          ox <= ox + XW'(1);
        end
      end
    end
  end

  // row/col are signed so padded taps can go negative
  always_comb begin
    row  = int'(oy) * STRIDE + int'(ky) - P;
    col  = int'(ox) * STRIDE + int'(kx) - P;
    addr = base_q + ADDR_WIDTH'(row * IMG_W + col);
    tap  = TW'(int'(ky) * KERNEL + int'(kx));
`ifdef WINDOW_LOADER_PAD_EN
    inb  = (row >= 0) && (row < IMG_H) &&
           (col >= 0) && (col < IMG_W);
`else
    inb  = 1'b1;
`endif
  end

endmodule

// File: rtl/window_loader.sv
// Streams KERNELxKERNEL SRAM windows into the peek/pop FIFO.
// WINDOW_LOADER_PAD_EN enables zero-padded borders.
module window_loader
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int STRIDE     = 1,
  parameter int ADDR_WIDTH = 16,
  localparam int NTAP      = ntap(KERNEL)
) (
  input  logic                                i_clk,
  input  logic                                i_nrst,
  input  logic                                i_start,
  input  logic [ADDR_WIDTH-1:0]               i_base_addr,
  output logic                                o_sram_ren,
  output logic [ADDR_WIDTH-1:0]               o_sram_addr,
  input  logic [DATA_WIDTH-1:0]               i_sram_rdata,
  output logic [0:NTAP-1][DATA_WIDTH-1:0]     o_fifo_data,
  output logic                                o_fifo_write_en,
  output logic                                o_fifo_clear,
  input  logic                                i_fifo_empty,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int TW = $clog2(NTAP);

  loader_state_t         state, state_n;
  logic                  we_n, clr_n, done_n, busy_n;
  logic                  load, step_tap, step_win;
  logic                  inb, last_tap, last_win;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [TW-1:0]         tap, slot;
  logic                  pend, pend_rd;

  window_addr_gen #(
    .KERNEL     (KERNEL),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .STRIDE     (STRIDE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .load     (load),
    .step_tap (step_tap),
    .step_win (step_win),
    .base     (i_base_addr),
    .addr     (gen_addr),
    .inb      (inb),
    .tap      (tap),
    .last_tap (last_tap),
    .last_win (last_win)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (i_start) state_n = FETCH;
      FETCH:   if (last_tap) state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = WAIT;
      WAIT:    if (i_fifo_empty) state_n = CLEAR;
      CLEAR:   state_n = last_win ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    we_n        = (state_n == WRITE);
    clr_n       = (state_n == CLEAR);
    done_n      = (state == CLEAR) && last_win;
    busy_n      = (state_n != IDLE);
    load        = (state == IDLE) && i_start;
    step_tap    = (state == FETCH);
    step_win    = (state == CLEAR) && !last_win;
    o_sram_ren  = step_tap && inb;
    o_sram_addr = o_sram_ren ? gen_addr : '0;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_fifo_write_en <= 1'b0;
      o_fifo_clear    <= 1'b0;
      o_done          <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_fifo_write_en <= we_n;
      o_fifo_clear    <= clr_n;
      o_done          <= done_n;
      o_busy          <= busy_n;
    end
  end

  // Read data lands one cycle late; padded taps store zero.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pend        <= 1'b0;
      pend_rd     <= 1'b0;
      slot        <= '0;
      o_fifo_data <= '0;
    end else begin
      pend    <= step_tap;
      pend_rd <= o_sram_ren;
      slot    <= tap;
      if (pend)
        o_fifo_data[slot] <= pend_rd ? i_sram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader on a 4x4 map.
// Padded checks build with WINDOW_LOADER_PAD_EN.
module tb_window_loader;

  localparam int DW = 8;
  localparam int K  = 3;
  localparam int NT = 9;
  localparam int AW = 16;

  typedef logic [0:NT-1][DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [AW-1:0] base = '0;
  logic          ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata = '0;
  win_t          fdata;
  logic          we, clr, busy, done;

  int off = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int we_cnt, clr_cnt, done_cnt, ren_cnt, dbl, clr_cyc;
  logic pend_w;
  win_t win_q[$];
  int   rens_q[$];
  int   addr_q[$];
  int   we_cyc[$];

  int w0[NT] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int w1[NT] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  int w2[NT] = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
  int w3[NT] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
  int p0[NT] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};

  window_loader #(
    .DATA_WIDTH (DW),
    .KERNEL     (K),
    .IMG_W      (4),
    .IMG_H      (4),
    .STRIDE     (1),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_start         (start),
    .i_base_addr     (base),
    .o_sram_ren      (ren),
    .o_sram_addr     (addr),
    .i_sram_rdata    (rdata),
    .o_fifo_data     (fdata),
    .o_fifo_write_en (we),
    .o_fifo_clear    (clr),
    .i_fifo_empty    (fifo_empty),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren) rdata <= DW'(int'(addr) - off);
  end

  always @(negedge clk) begin
    if (nrst) begin
      if (ren) begin
        ren_cnt++;
        addr_q.push_back(int'(addr));
      end
      if (we) begin
        if (pend_w) dbl++;
        pend_w = 1'b1;
        we_cnt++;
        win_q.push_back(fdata);
        rens_q.push_back(ren_cnt);
        we_cyc.push_back(cyc);
      end
      if (clr) begin
        pend_w = 1'b0;
        clr_cnt++;
        ren_cnt = 0;
        clr_cyc = cyc;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mon_clr();
    we_cnt = 0;
    clr_cnt = 0;
    done_cnt = 0;
    ren_cnt = 0;
    dbl = 0;
    clr_cyc = -1;
    pend_w = 1'b0;
    win_q.delete();
    rens_q.delete();
    addr_q.delete();
    we_cyc.delete();
  endtask

  task automatic go(input int b);
    base  = AW'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic chk_win(input string tag, input int idx,
                         input int e[NT]);
    if (idx >= win_q.size()) begin
      chk({tag, "_missing"}, win_q.size(), idx + 1);
      return;
    end
    for (int t = 0; t < NT; t++)
      chk($sformatf("%s_t%0d", tag, t), win_q[idx][t], e[t]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ren"}, ren, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_clr"}, clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data0"}, (fdata == '0), 1);
  endtask

  initial begin
    int s, n, r;
    mon_clr();
    tick();
    tick();
    chk_idle("rst");
    nrst = 1'b1;
    tick();

`ifndef WINDOW_LOADER_PAD_EN
    mon_clr();
    off = 0;
    go(0);
    s = cyc;
    chk("ren_after_start", ren, 1);
    chk("busy_after_start", busy, 1);
    wait_done("run1_done");
    chk("run1_writes", we_cnt, 4);
    chk("run1_clears", clr_cnt, 4);
    chk("run1_busy_low", busy, 0);
    chk("run1_w0_reads", rens_q[0], 9);
    chk("first_write_lat", we_cyc[0] - s, 10);
    chk("window_period", we_cyc[1] - we_cyc[0], 13);
    chk_win("run1_w0", 0, w0);
    chk_win("run1_w1", 1, w1);
    chk_win("run1_w2", 2, w2);
    chk_win("run1_w3", 3, w3);

    mon_clr();
    off = 100;
    go(100);
    wait_done("base_done");
    chk("base_a0", addr_q[0], 100);
    chk("base_a1", addr_q[1], 101);
    chk("base_a2", addr_q[2], 102);
    chk("base_a3", addr_q[3], 104);
    chk_win("base_w0", 0, w0);
    chk_win("base_w3", 3, w3);

    mon_clr();
    off = 0;
    fifo_empty = 1'b0;
    go(0);
    n = 0;
    while (we_cnt == 0 && n < 100) begin
      tick();
      n++;
    end
    chk("hold_write_seen", we_cnt, 1);
    repeat (20) tick();
    chk("hold_no_clr", clr_cnt, 0);
    chk("hold_busy", busy, 1);
    chk("hold_data_kept", (fdata == win_q[0]), 1);
    fifo_empty = 1'b1;
    r = cyc;
    tick();
    tick();
    chk("hold_clr_lat", clr_cyc - r, 1);
    wait_done("hold_done");
    chk("hold_writes", we_cnt, 4);

    mon_clr();
    go(0);
    tick();
    tick();
    base  = AW'(50);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start_done");
    chk("busy_start_writes", we_cnt, 4);
    chk("busy_start_a0", addr_q[0], 0);
    chk_win("busy_start_w0", 0, w0);
    chk_win("busy_start_w3", 3, w3);

    mon_clr();
    go(0);
    n = 0;
    while (clr_cnt < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_reset_reach", clr_cnt, 2);
    tick();
    tick();
    nrst = 1'b0;
    #1;
    chk_idle("mid_reset");
    tick();
    nrst = 1'b1;
    tick();
    mon_clr();
    go(0);
    wait_done("restart_done");
    chk("restart_writes", we_cnt, 4);
    chk_win("restart_w0", 0, w0);
    chk("one_write_per_clear", dbl, 0);
`else
    mon_clr();
    off = 0;
    go(0);
    chk("pad_ren_tap0", ren, 0);
    wait_done("pad_done");
    chk("pad_writes", we_cnt, 16);
    chk("pad_clears", clr_cnt, 16);
    chk("pad_w0_reads", rens_q[0], 4);
    chk("pad_w5_reads", rens_q[5], 9);
    chk_win("pad_w0", 0, p0);
    chk_win("pad_w5", 5, w0);
    chk("one_write_per_clear", dbl, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
